// File: rtl/vga_scan_engine.sv
// VGA raster timing and video-RAM fetch address generator.
// Every output is registered and reflects the hcount/vcount it is presented with.
module vga_scan_engine #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 400,
  parameter int V_FRONT   = 12,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 35,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CLK_DIV   = 2,
  parameter int ADDR_W    = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [1:0]        line_repeat,
  input  logic [1:0]        fetch_log2,
  output logic              px_en,
  output logic [10:0]       hcount,
  output logic [9:0]        vcount,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              fetch,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]  div_q, div_n;
  logic              px_n;
  logic              h_wrap, frame_wrap;
  logic [10:0]       h_next;
  logic [9:0]        v_next;
  logic [ADDR_W-1:0] addr_step, addr_n, line_start, line_n;
  logic [1:0]        rep_cnt, rep_n, rep_sh, rep_sh_n, fl_sh, fl_sh_n;
  logic [10:0]       fmask;
  logic              de_n, fetch_n, hs_n, vs_n;

  always_comb begin
    div_n      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    px_n       = (div_n == DIV_LAST);

    h_wrap     = (hcount == H_LAST);
    frame_wrap = h_wrap && (vcount == V_LAST);
    h_next     = h_wrap ? 11'd0 : hcount + 11'd1;
    v_next     = vcount;
    if (h_wrap)
      v_next = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;

    // shadow settings switch over exactly when the raster returns to (0,0)
    rep_sh_n   = frame_wrap ? line_repeat : rep_sh;
    fl_sh_n    = frame_wrap ? fetch_log2  : fl_sh;

    addr_step  = fetch ? ram_addr + 1'b1 : ram_addr;
    addr_n     = addr_step;
    line_n     = line_start;
    rep_n      = rep_cnt;
    if (frame_wrap) begin
      addr_n = base_addr;
      line_n = base_addr;
      rep_n  = 2'd0;
    end else if ((h_next == H_VIS) && (v_next < V_VIS)) begin
      if (rep_cnt < rep_sh) begin
        addr_n = line_start;
        rep_n  = rep_cnt + 2'd1;
      end else begin
        rep_n  = 2'd0;
        line_n = addr_step;
      end
    end

    de_n    = (h_next < H_VIS) && (v_next < V_VIS);
    fmask   = (11'd1 << fl_sh_n) - 11'd1;
    fetch_n = de_n && ((h_next & fmask) == 11'd0);
    hs_n    = ((h_next >= HS_START) && (h_next < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vs_n    = ((v_next >= VS_START) && (v_next < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q       <= '0;
      px_en       <= (DIV_LAST == '0);
      hcount      <= 11'd0;
      vcount      <= 10'd0;
      de          <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      fetch       <= 1'b0;
      frame_start <= 1'b0;
      ram_addr    <= '0;
      line_start  <= '0;
      rep_cnt     <= 2'd0;
      rep_sh      <= line_repeat;
      fl_sh       <= fetch_log2;
    end else begin
      div_q <= div_n;
      px_en <= px_n;
      if (px_en) begin
        hcount      <= h_next;
        vcount      <= v_next;
        de          <= de_n;
        hsync       <= hs_n;
        vsync       <= vs_n;
        fetch       <= fetch_n;
        frame_start <= frame_wrap;
        ram_addr    <= addr_n;
        line_start  <= line_n;
        rep_cnt     <= rep_n;
        rep_sh      <= rep_sh_n;
        fl_sh       <= fl_sh_n;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine on a reduced raster: a reference model queues the
// expected outputs every clock and the negedge checker pops and compares them.
module tb_vga_scan_engine;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam bit HP = 1'b0, VP = 1'b1;
  localparam int CLK_DIV = 2;
  localparam int AW = 15;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] base_addr;
  logic [1:0]    line_repeat, fetch_log2;
  logic          px_en, de, hsync, vsync, fetch, frame_start;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic [AW-1:0] ram_addr;

  vga_scan_engine #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .CLK_DIV(CLK_DIV), .ADDR_W(AW)
  ) dut (
    .clock(clock), .reset(reset), .base_addr(base_addr),
    .line_repeat(line_repeat), .fetch_log2(fetch_log2),
    .px_en(px_en), .hcount(hcount), .vcount(vcount), .de(de),
    .hsync(hsync), .vsync(vsync), .fetch(fetch), .ram_addr(ram_addr),
    .frame_start(frame_start)
  );

  always #10 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          px;
    logic [10:0]   h;
    logic [9:0]    v;
    logic          de, hs, vs, fe, fs;
    logic [AW-1:0] addr;
    logic          started;
  } exp_t;

  exp_t sb_q[$];

  int            cyc = 0;
  int            m_div, m_h, m_v, m_frames = 0;
  logic          m_de, m_fe, m_fs, m_hs, m_vs, m_started;
  logic [AW-1:0] m_addr, m_line, s_base;
  int            m_rep, s_rep, s_fl;

  // reference model, written from the raster/fetch rules directly
  always @(posedge clock) begin
    exp_t e;
    cyc++;
    if (reset) begin
      m_div = 0; m_h = 0; m_v = 0;
      m_de = 0; m_fe = 0; m_fs = 0; m_hs = !HP; m_vs = !VP;
      m_addr = '0; m_line = '0; m_rep = 0; m_started = 0;
      s_base = base_addr; s_rep = line_repeat; s_fl = fetch_log2;
    end else if (m_div == CLK_DIV - 1) begin
      m_div = 0;
      if (m_fe) m_addr = m_addr + 1'b1;
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
      m_fs = (m_h == 0 && m_v == 0);
      if (m_fs) begin
        s_base = base_addr; s_rep = line_repeat; s_fl = fetch_log2;
        m_addr = s_base; m_line = s_base; m_rep = 0;
        m_started = 1; m_frames++;
      end else if (m_h == HV && m_v < VV) begin
        if (m_rep < s_rep) begin
          m_addr = m_line; m_rep++;
        end else begin
          m_rep = 0; m_line = m_addr;
        end
      end
      m_de = (m_h < HV) && (m_v < VV);
      m_fe = m_de && ((m_h % (1 << s_fl)) == 0);
      m_hs = (m_h >= HV + HF && m_h < HV + HF + HS) ? HP : !HP;
      m_vs = (m_v >= VV + VF && m_v < VV + VF + VS) ? VP : !VP;
    end else begin
      m_div++;
    end
    e.px = (m_div == CLK_DIV - 1);
    e.h = 11'(m_h); e.v = 10'(m_v);
    e.de = m_de; e.hs = m_hs; e.vs = m_vs; e.fe = m_fe; e.fs = m_fs;
    e.addr = m_addr; e.started = m_started;
    sb_q.push_back(e);
  end

  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_eq("px_en", px_en, e.px);
      chk_eq("hcount", hcount, e.h);
      chk_eq("vcount", vcount, e.v);
      chk_eq("de", de, e.de);
      chk_eq("hsync", hsync, e.hs);
      chk_eq("vsync", vsync, e.vs);
      chk_eq("frame_start", frame_start, e.fs);
      if (e.started) begin
        chk_eq("fetch", fetch, e.fe);
        chk_eq("ram_addr", ram_addr, e.addr);
      end
    end
  end

  task automatic wait_frame();
    int f0 = m_frames;
    int c  = 0;
    while (m_frames == f0 && c < 2000) begin
      @(negedge clock);
      c++;
    end
    if (m_frames == f0) chk_eq("wait_frame_timeout", 1, 0);
  endtask

  task automatic wait_line(input int v);
    int c = 0;
    while (m_v != v && c < 2000) begin
      @(negedge clock);
      c++;
    end
    if (m_v != v) chk_eq("wait_line_timeout", 1, 0);
  endtask

  task automatic wait_fs_rise(output int t);
    int c = 0;
    while (frame_start && c < 2000) begin @(negedge clock); c++; end
    while (!frame_start && c < 2000) begin @(negedge clock); c++; end
    if (!frame_start) chk_eq("frame_start_timeout", 1, 0);
    t = cyc;
  endtask

  initial begin
    int t0, t1, c;
    reset = 1'b1; base_addr = '0; line_repeat = 2'd0; fetch_log2 = 2'd3;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // frame period and plain 8-pixel fetches from base 0
    wait_fs_rise(t0);
    wait_fs_rise(t1);
    chk_eq("frame_period", t1 - t0, HT * VT * CLK_DIV);
    wait_frame();

    // line repeat once, high plane
    line_repeat = 2'd1; base_addr = 15'h4000;
    wait_frame();
    wait_frame();

    // base change mid-frame only takes effect at the next frame start
    line_repeat = 2'd0; base_addr = 15'h0000;
    wait_frame();
    wait_line(3);
    base_addr = 15'h0100;
    wait_frame();
    chk_eq("base_next_frame", ram_addr, 15'h0100);
    chk_eq("fetch_at_origin", fetch, 1);

    // per-pixel fetch wrapping the address space within line 0
    base_addr = 15'h7FF8; fetch_log2 = 2'd0;
    wait_frame();
    wait_frame();

    // maximum repeat with 4-pixel fetches
    base_addr = 15'h1234; fetch_log2 = 2'd2; line_repeat = 2'd3;
    wait_frame();
    wait_frame();

    // reset pulse in the middle of a visible line
    c = 0;
    while (!(m_h == 12 && m_v == 4) && c < 2000) begin @(negedge clock); c++; end
    if (!(m_h == 12 && m_v == 4)) chk_eq("wait_pos_timeout", 1, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_eq("rst_hcount", hcount, 0);
    chk_eq("rst_vcount", vcount, 0);
    chk_eq("rst_de", de, 0);
    chk_eq("rst_ram_addr", ram_addr, 0);
    c = 0;
    while (hcount == 11'd0 && c < 20) begin @(negedge clock); c++; end
    chk_eq("rst_first_advance", c, CLK_DIV);
    wait_frame();
    wait_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
